// File: rtl/shifter_pkg.sv
// shifter_pkg: mode encodings shared by the shift register and its cells
package shifter_pkg;
  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_SHR  = 2'd1;
  localparam logic [1:0] MODE_SHL  = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;
endpackage

// File: rtl/shifter_cell.sv
// shifter_cell: one register bit with a hold/shift-right/shift-left/load next-state mux
module shifter_cell
  import shifter_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] s,
  input  logic       lft,
  input  logic       rgt,
  input  logic       ld,
  output logic       q
);
  // clear wins; an unknown mode falls through to hold
  always_ff @(posedge clk) begin
    if (clr) q <= 1'b0;
    else
      case (s)
        MODE_HOLD: q <= q;
        MODE_SHR:  q <= lft;
        MODE_SHL:  q <= rgt;
        MODE_LOAD: q <= ld;
        default:   q <= q;
      endcase
  end
endmodule

// File: rtl/shifter.sv
// shifter: 74194-style universal shift register built from per-bit cells
module shifter
  import shifter_pkg::*;
#(
  parameter int bit_width = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [bit_width-1:0] din,
  input  logic [1:0]           s,
  input  logic                 srsi,
  input  logic                 slsi,
  output logic [bit_width-1:0] dout
);
  logic [bit_width-1:0] lft, rgt;
  assign lft = {srsi, dout[bit_width-1:1]};
  assign rgt = {dout[bit_width-2:0], slsi};
  for (genvar i = 0; i < bit_width; i++) begin : g_cell
    shifter_cell u_cell (
      .clk(clk),
      .clr(clr),
      .s(s),
      .lft(lft[i]),
      .rgt(rgt[i]),
      .ld(din[i]),
      .q(dout[i])
    );
  end
endmodule

// File: tb/tb_shifter.sv
// tb_shifter: directed scoreboard bench for 8-bit and 4-bit shift registers
module tb_shifter;
  typedef struct {
    logic [7:0] v;
    string      n;
  } exp_t;
  logic       clk = 1'b0;
  logic       clr8 = 1'b1, clr4 = 1'b1;
  logic [7:0] din8 = 8'h00;
  logic [3:0] din4 = 4'h0;
  logic [1:0] s8 = 2'd0, s4 = 2'd0;
  logic       srsi8 = 1'b0, slsi8 = 1'b0, srsi4 = 1'b0, slsi4 = 1'b0;
  logic [7:0] dout8;
  logic [3:0] dout4;
  exp_t       q8[$], q4[$];
  int         compared = 0, mismatched = 0;
  logic [7:0] shr_exp [8] = '{8'h86, 8'hC3, 8'hE1, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] shl0_exp [8] = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [7:0] shl1_exp [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
  logic [1:0] mix_s [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] mix_exp [5] = '{8'hCD, 8'hCD, 8'hE6, 8'hCC, 8'hCD};

  always #5 clk = ~clk;

  shifter #(.bit_width(8)) u_dut8 (
    .clk(clk), .clr(clr8), .din(din8), .s(s8), .srsi(srsi8), .slsi(slsi8), .dout(dout8)
  );
  shifter #(.bit_width(4)) u_dut4 (
    .clk(clk), .clr(clr4), .din(din4), .s(s4), .srsi(srsi4), .slsi(slsi4), .dout(dout4)
  );

  // each edge produces one output per queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      compared++;
      if (dout8 !== e.v) begin
        mismatched++;
        $display("FAIL %s: dout=%h expected=%h", e.n, dout8, e.v);
      end
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      compared++;
      if ({4'h0, dout4} !== e.v) begin
        mismatched++;
        $display("FAIL %s: dout=%h expected=%h", e.n, dout4, e.v[3:0]);
      end
    end
  end

  task automatic step8(input logic c, input logic [1:0] m, input logic [7:0] d,
                       input logic r, input logic l, input logic [7:0] x, input string n);
    @(negedge clk);
    clr8 = c; s8 = m; din8 = d; srsi8 = r; slsi8 = l;
    q8.push_back('{x, n});
    @(posedge clk);
  endtask

  task automatic step4(input logic c, input logic [1:0] m, input logic [3:0] d,
                       input logic r, input logic l, input logic [3:0] x, input string n);
    @(negedge clk);
    clr4 = c; s4 = m; din4 = d; srsi4 = r; slsi4 = l;
    q4.push_back('{{4'h0, x}, n});
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) step8(1, 2'd3, 8'h0D, 0, 0, 8'h00, "reset_over_load");
    step8(0, 2'd3, 8'h0D, 0, 0, 8'h0D, "load");
    for (int i = 0; i < 10; i++) step8(0, 2'd0, 8'hFF, 1, 1, 8'h0D, "hold");
    for (int i = 0; i < 8; i++) step8(0, 2'd1, 8'h8D, 1, 0, shr_exp[i], "shift_right");
    step8(0, 2'd3, 8'h0F, 0, 0, 8'h0F, "load_0f");
    for (int i = 0; i < 8; i++) step8(0, 2'd2, 8'hAA, 1, 0, shl0_exp[i], "shift_left_0");
    for (int i = 0; i < 8; i++) step8(0, 2'd2, 8'h55, 0, 1, shl1_exp[i], "shift_left_1");
    for (int i = 0; i < 5; i++) step8(0, mix_s[i], 8'hCD, 1, 0, mix_exp[i], "mode_switch");
    step8(1, 2'd1, 8'hCD, 1, 0, 8'h00, "clear_mid");
    step8(0, 2'd1, 8'hCD, 1, 0, 8'h80, "clear_release_shift");
    step4(1, 2'd3, 4'h9, 0, 0, 4'h0, "w4_reset");
    step4(0, 2'd3, 4'h9, 0, 0, 4'h9, "w4_load");
    step4(1, 2'd2, 4'h9, 0, 1, 4'h0, "w4_clear");
    step4(0, 2'd2, 4'h9, 0, 1, 4'h1, "w4_shl_a");
    step4(0, 2'd2, 4'h9, 0, 1, 4'h3, "w4_shl_b");
    step4(0, 2'd1, 4'h9, 0, 1, 4'h1, "w4_shr");
    repeat (3) @(negedge clk);
    if (q8.size() + q4.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: pending=%0d expected=0", q8.size() + q4.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
